// File: rtl/mand_dispatcher.sv
// mand_dispatcher
//   Sweeps a rectangular pixel region of the complex plane in raster order and
//   shares NUM_SOLVERS mandelbrot solvers between the pixels. Each free solver
//   is loaded by holding its c value and pulsing its reset. Finished iteration
//   counts are collected round-robin and streamed out, tagged with the pixel
//   coordinates, through a valid/ready port.
//
// Ports
//   clock_i, reset_n_i      system clock, asynchronous active-low reset
//   start_i                 one-cycle sweep start (ignored while busy)
//   re_start_i, im_start_i  signed 7.20 c of pixel (0,0)
//   step_i                  signed 7.20 pixel pitch
//   width_i, height_i       region size in pixels
//   busy_o, done_o          sweep in progress / one-cycle completion pulse
//   solver_reset_o          per-solver load strobe
//   solver_c_re_o/_im_o     per-solver c, slot i at [27i+26:27i]
//   solver_ready_i          per-solver result-complete flag
//   solver_out_i            per-solver iteration count, slot i at [32i+31:32i]
//   result_valid_o/ready_i  result handshake
//   result_x_o/_y_o/_iter_o result payload
//
// Top FSM
//   state   | meaning
//   IDLE    | waiting for start
//   RUN     | dispatching pixels and collecting results
// Slot FSM
//   FREE    | solver available for the next pixel
//   LOAD    | solver_reset high, c presented to the solver
//   BUSY    | solver iterating; result taken when solver_ready is high
module mand_dispatcher #(
    parameter int NUM_SOLVERS = 4,
    parameter int COORD_BITS  = 10
) (
    input  logic                      clock_i,
    input  logic                      reset_n_i,
    input  logic                      start_i,
    input  logic [26:0]               re_start_i,
    input  logic [26:0]               im_start_i,
    input  logic [26:0]               step_i,
    input  logic [COORD_BITS-1:0]     width_i,
    input  logic [COORD_BITS-1:0]     height_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [NUM_SOLVERS-1:0]    solver_reset_o,
    output logic [27*NUM_SOLVERS-1:0] solver_c_re_o,
    output logic [27*NUM_SOLVERS-1:0] solver_c_im_o,
    input  logic [NUM_SOLVERS-1:0]    solver_ready_i,
    input  logic [32*NUM_SOLVERS-1:0] solver_out_i,
    output logic                      result_valid_o,
    input  logic                      result_ready_i,
    output logic [COORD_BITS-1:0]     result_x_o,
    output logic [COORD_BITS-1:0]     result_y_o,
    output logic [31:0]               result_iter_o
);
    localparam int IW = (NUM_SOLVERS > 1) ? $clog2(NUM_SOLVERS) : 1;

    typedef enum logic {ST_IDLE, ST_RUN} top_state_e;
    typedef enum logic [1:0] {SL_FREE, SL_LOAD, SL_BUSY} slot_state_e;

    top_state_e              state_q, state_d;
    slot_state_e             slot_q [NUM_SOLVERS];
    slot_state_e             slot_d [NUM_SOLVERS];
    logic [26:0]             re_start_q, re_start_d, step_q, step_d;
    logic [26:0]             cur_re_q, cur_re_d, cur_im_q, cur_im_d;
    logic [COORD_BITS-1:0]   width_q, width_d, height_q, height_d;
    logic [COORD_BITS-1:0]   x_q, x_d, y_q, y_d;
    logic                    pend_q, pend_d;
    logic [26:0]             c_re_q [NUM_SOLVERS];
    logic [26:0]             c_re_d [NUM_SOLVERS];
    logic [26:0]             c_im_q [NUM_SOLVERS];
    logic [26:0]             c_im_d [NUM_SOLVERS];
    logic [COORD_BITS-1:0]   sx_q [NUM_SOLVERS];
    logic [COORD_BITS-1:0]   sx_d [NUM_SOLVERS];
    logic [COORD_BITS-1:0]   sy_q [NUM_SOLVERS];
    logic [COORD_BITS-1:0]   sy_d [NUM_SOLVERS];
    logic [NUM_SOLVERS-1:0]  sreset_q, sreset_d;
    logic [IW-1:0]           rr_q, rr_d;
    logic                    valid_q, valid_d;
    logic [COORD_BITS-1:0]   res_x_q, res_x_d, res_y_q, res_y_d;
    logic [31:0]             res_iter_q, res_iter_d;
    logic                    done;
    logic [31:0]             sol_out [NUM_SOLVERS];
    logic                    free_found, all_free, coll_found;
    logic [IW-1:0]           free_idx, coll_idx, probe;

    for (genvar g = 0; g < NUM_SOLVERS; g++) begin : g_pack
        assign solver_c_re_o[27*g +: 27] = c_re_q[g];
        assign solver_c_im_o[27*g +: 27] = c_im_q[g];
        assign sol_out[g]                = solver_out_i[32*g +: 32];
    end

    // Lowest-index free slot wins dispatch.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        all_free   = 1'b1;
        for (int i = NUM_SOLVERS - 1; i >= 0; i--) begin
            if (slot_q[i] == SL_FREE) begin
                free_found = 1'b1;
                free_idx   = IW'(i);
            end else begin
                all_free = 1'b0;
            end
        end
    end

    // Round-robin: search starts at the slot after the last one collected.
    always_comb begin
        coll_found = 1'b0;
        coll_idx   = '0;
        probe      = '0;
        for (int k = NUM_SOLVERS - 1; k >= 0; k--) begin
            probe = IW'((int'(rr_q) + 1 + k) % NUM_SOLVERS);
            if (slot_q[probe] == SL_BUSY && solver_ready_i[probe]) begin
                coll_found = 1'b1;
                coll_idx   = probe;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        re_start_d = re_start_q;
        step_d     = step_q;
        cur_re_d   = cur_re_q;
        cur_im_d   = cur_im_q;
        width_d    = width_q;
        height_d   = height_q;
        x_d        = x_q;
        y_d        = y_q;
        pend_d     = pend_q;
        rr_d       = rr_q;
        valid_d    = valid_q;
        res_x_d    = res_x_q;
        res_y_d    = res_y_q;
        res_iter_d = res_iter_q;
        sreset_d   = '0;
        done       = 1'b0;
        for (int i = 0; i < NUM_SOLVERS; i++) begin
            slot_d[i] = (slot_q[i] == SL_LOAD) ? SL_BUSY : slot_q[i];
            c_re_d[i] = c_re_q[i];
            c_im_d[i] = c_im_q[i];
            sx_d[i]   = sx_q[i];
            sy_d[i]   = sy_q[i];
        end

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d    = ST_RUN;
                    re_start_d = re_start_i;
                    step_d     = step_i;
                    width_d    = width_i;
                    height_d   = height_i;
                    cur_re_d   = re_start_i;
                    cur_im_d   = im_start_i;
                    x_d        = '0;
                    y_d        = '0;
                    pend_d     = (width_i != '0) && (height_i != '0);
                end
            end
            ST_RUN: begin
                if (!valid_q || result_ready_i) begin
                    valid_d = coll_found;
                    if (coll_found) begin
                        res_x_d          = sx_q[coll_idx];
                        res_y_d          = sy_q[coll_idx];
                        res_iter_d       = sol_out[coll_idx];
                        slot_d[coll_idx] = SL_FREE;
                        rr_d             = coll_idx;
                    end
                end
                if (pend_q && free_found) begin
                    slot_d[free_idx]   = SL_LOAD;
                    c_re_d[free_idx]   = cur_re_q;
                    c_im_d[free_idx]   = cur_im_q;
                    sx_d[free_idx]     = x_q;
                    sy_d[free_idx]     = y_q;
                    sreset_d[free_idx] = 1'b1;
                    if (x_q == width_q - COORD_BITS'(1)) begin
                        x_d      = '0;
                        cur_re_d = re_start_q;
                        cur_im_d = cur_im_q - step_q;   // imaginary axis decreases downward
                        if (y_q == height_q - COORD_BITS'(1)) begin
                            pend_d = 1'b0;
                        end else begin
                            y_d = y_q + COORD_BITS'(1);
                        end
                    end else begin
                        x_d      = x_q + COORD_BITS'(1);
                        cur_re_d = cur_re_q + step_q;
                    end
                end
                if (!pend_q && all_free && !valid_q) begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= ST_IDLE;
            re_start_q <= '0;
            step_q     <= '0;
            cur_re_q   <= '0;
            cur_im_q   <= '0;
            width_q    <= '0;
            height_q   <= '0;
            x_q        <= '0;
            y_q        <= '0;
            pend_q     <= 1'b0;
            rr_q       <= IW'(NUM_SOLVERS - 1);
            valid_q    <= 1'b0;
            res_x_q    <= '0;
            res_y_q    <= '0;
            res_iter_q <= '0;
            sreset_q   <= '1;
            for (int i = 0; i < NUM_SOLVERS; i++) begin
                slot_q[i] <= SL_FREE;
                c_re_q[i] <= '0;
                c_im_q[i] <= '0;
                sx_q[i]   <= '0;
                sy_q[i]   <= '0;
            end
        end else begin
            state_q    <= state_d;
            re_start_q <= re_start_d;
            step_q     <= step_d;
            cur_re_q   <= cur_re_d;
            cur_im_q   <= cur_im_d;
            width_q    <= width_d;
            height_q   <= height_d;
            x_q        <= x_d;
            y_q        <= y_d;
            pend_q     <= pend_d;
            rr_q       <= rr_d;
            valid_q    <= valid_d;
            res_x_q    <= res_x_d;
            res_y_q    <= res_y_d;
            res_iter_q <= res_iter_d;
            sreset_q   <= sreset_d;
            for (int i = 0; i < NUM_SOLVERS; i++) begin
                slot_q[i] <= slot_d[i];
                c_re_q[i] <= c_re_d[i];
                c_im_q[i] <= c_im_d[i];
                sx_q[i]   <= sx_d[i];
                sy_q[i]   <= sy_d[i];
            end
        end
    end

    assign busy_o         = (state_q == ST_RUN);
    assign done_o         = done;
    assign solver_reset_o = sreset_q;
    assign result_valid_o = valid_q;
    assign result_x_o     = res_x_q;
    assign result_y_o     = res_y_q;
    assign result_iter_o  = res_iter_q;

endmodule

// File: tb/tb_mand_dispatcher.sv
// Bench for mand_dispatcher: behavioural solvers, raster dispatch scoreboard
// and per-pixel golden iteration counts.
module tb_mand_dispatcher;
    localparam int N      = 4;
    localparam int CB     = 10;
    localparam int MAXIT  = 16;
    localparam int BUDGET = 3000;

    localparam logic [26:0] FX_M2   = 27'(-2097152);
    localparam logic [26:0] FX_M15  = 27'(-1572864);
    localparam logic [26:0] FX_M05  = 27'(-524288);
    localparam logic [26:0] FX_P1   = 27'd1048576;
    localparam logic [26:0] FX_P05  = 27'd524288;
    localparam logic [26:0] FX_P025 = 27'd262144;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [26:0]     re_s = '0, im_s = '0, stp = '0;
    logic [CB-1:0]   wd = '0, ht = '0;
    logic            busy, done;
    logic [N-1:0]    sreset;
    logic [27*N-1:0] c_re, c_im;
    logic [N-1:0]    sol_ready;
    logic [32*N-1:0] sol_out;
    logic            rvalid;
    logic            rready = 1'b1;
    logic [CB-1:0]   rx, ry;
    logic [31:0]     rit;

    always #5 clk = ~clk;

    mand_dispatcher #(.NUM_SOLVERS(N), .COORD_BITS(CB)) dut (
        .clock_i(clk), .reset_n_i(rst_n), .start_i(start),
        .re_start_i(re_s), .im_start_i(im_s), .step_i(stp),
        .width_i(wd), .height_i(ht),
        .busy_o(busy), .done_o(done),
        .solver_reset_o(sreset), .solver_c_re_o(c_re), .solver_c_im_o(c_im),
        .solver_ready_i(sol_ready), .solver_out_i(sol_out),
        .result_valid_o(rvalid), .result_ready_i(rready),
        .result_x_o(rx), .result_y_o(ry), .result_iter_o(rit)
    );

    function automatic int mand_iter(input logic [26:0] cre, input logic [26:0] cim);
        longint cr, ci, zr, zi, t;
        cr = longint'($signed(cre));
        ci = longint'($signed(cim));
        zr = 0;
        zi = 0;
        for (int n = 1; n <= MAXIT; n++) begin
            t  = ((zr * zr - zi * zi) >>> 20) + cr;
            zi = ((2 * zr * zi) >>> 20) + ci;
            zr = t;
            if (zr * zr + zi * zi > (longint'(4) <<< 40)) return n;
        end
        return -1;
    endfunction

    // Behavioural solvers: latency depends on the result; in sim_mode each
    // slot's ready is withheld until all four are finished, then released together.
    bit          sim_mode = 1'b0;
    logic [N-1:0] s_rdy, hold;
    int          s_cnt [N];
    logic [31:0] s_val [N];

    always @(posedge clk) begin
        int it;
        if (!sim_mode) hold <= '0;
        else if (&hold && &s_rdy) hold <= '0;
        for (int i = 0; i < N; i++) begin
            if (sreset[i]) begin
                it       = mand_iter(c_re[27*i +: 27], c_im[27*i +: 27]);
                s_val[i] <= 32'(it);
                s_cnt[i] <= (it < 0) ? 11 : (it % 8) + 2;
                s_rdy[i] <= 1'b0;
                if (sim_mode) hold[i] <= 1'b1;
            end else if (s_cnt[i] > 1) begin
                s_cnt[i] <= s_cnt[i] - 1;
            end else begin
                s_rdy[i] <= 1'b1;
            end
        end
    end

    assign sol_ready = s_rdy & ~hold;
    for (genvar g = 0; g < N; g++) begin : g_out
        assign sol_out[32*g +: 32] = s_val[g];
    end

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          pix;
        logic [26:0] re;
        logic [26:0] im;
    } disp_t;

    disp_t       exp_q[$];
    int          exp_iter [64];
    bit          seen [64];
    logic [26:0] disp_re [64];
    logic [26:0] disp_im [64];
    int          acc_pix[$];
    int          acc_cyc[$];

    task automatic run_sweep(input logic [26:0] rs, input logic [26:0] is, input logic [26:0] st,
                             input int w, input int h, input int rmode, input int restart_cyc,
                             output int nres, output int nd, output int ndone,
                             output int done_lat, output int stray);
        int cyc, pidx;
        bit fin, pv, pr;
        logic [CB-1:0] px, py;
        logic [31:0] pit;
        logic [26:0] cr, ci;
        disp_t e;
        exp_q.delete();
        acc_pix.delete();
        acc_cyc.delete();
        for (int p = 0; p < 64; p++) seen[p] = 1'b0;
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                cr = rs + 27'(x) * st;
                ci = is - 27'(y) * st;
                exp_q.push_back('{y * w + x, cr, ci});
                exp_iter[y * w + x] = mand_iter(cr, ci);
            end
        end
        nres = 0; nd = 0; ndone = 0; done_lat = -1; stray = 0;
        fin = 1'b0; pv = 1'b0; pr = 1'b0; px = '0; py = '0; pit = '0;
        @(negedge clk);
        re_s = rs; im_s = is; stp = st; wd = CB'(w); ht = CB'(h);
        rready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        cyc = 1;
        while (!fin && cyc < BUDGET) begin
            start  = (cyc == restart_cyc);
            wd     = start ? CB'(w + 2) : CB'(w);
            rready = (rmode == 0) ? 1'b1 : (cyc % 3 == 0);
            for (int i = 0; i < N; i++) begin
                if (sreset[i] && !busy) stray++;
                else if (sreset[i]) begin
                    nd++;
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL dispatch_extra slot %0d: got a load, required none", i);
                    end else begin
                        e = exp_q.pop_front();
                        disp_re[e.pix] = c_re[27*i +: 27];
                        disp_im[e.pix] = c_im[27*i +: 27];
                        if (c_re[27*i +: 27] !== e.re || c_im[27*i +: 27] !== e.im) begin
                            bad++;
                            $display("FAIL dispatch_c pixel %0d slot %0d: got %h/%h required %h/%h",
                                     e.pix, i, c_re[27*i +: 27], c_im[27*i +: 27], e.re, e.im);
                        end
                    end
                end
            end
            if (pv && !pr) begin
                total++;
                if (rvalid !== 1'b1 || rx !== px || ry !== py || rit !== pit) begin
                    bad++;
                    $display("FAIL result_stable: got v=%b %0d,%0d,%0d required v=1 %0d,%0d,%0d",
                             rvalid, rx, ry, rit, px, py, pit);
                end
            end
            if (rvalid === 1'b1 && rready) begin
                total++;
                pidx = int'(ry) * w + int'(rx);
                if (int'(rx) >= w || int'(ry) >= h || seen[pidx]) begin
                    bad++;
                    $display("FAIL result_pixel: got (%0d,%0d) required an unseen pixel inside %0dx%0d",
                             rx, ry, w, h);
                end else begin
                    seen[pidx] = 1'b1;
                    nres++;
                    acc_pix.push_back(pidx);
                    acc_cyc.push_back(cyc);
                    if (rit !== 32'(exp_iter[pidx])) begin
                        bad++;
                        $display("FAIL result_iter (%0d,%0d): got %0d required %0d",
                                 rx, ry, $signed(rit), exp_iter[pidx]);
                    end
                end
            end
            if (ndone > 0 && done !== 1'b1) begin
                total++;
                if (busy !== 1'b0) begin
                    bad++;
                    $display("FAIL busy_after_done: got %b required 0", busy);
                end
                fin = 1'b1;
            end else if (done === 1'b1) begin
                ndone++;
                if (done_lat < 0) done_lat = cyc;
                total++;
                if (busy !== 1'b1 || rvalid !== 1'b0) begin
                    bad++;
                    $display("FAIL done_cycle: got busy=%b valid=%b required busy=1 valid=0", busy, rvalid);
                end
            end
            pv = rvalid; pr = rready; px = rx; py = ry; pit = rit;
            if (!fin) begin
                @(negedge clk);
                cyc++;
            end
        end
        if (!fin) begin
            total++;
            bad++;
            $display("FAIL sweep_timeout: got no completion in %0d cycles, required done", BUDGET);
        end
        start = 1'b0;
        wd = CB'(w);
        rready = 1'b1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL dispatch_count: got %0d undispatched, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || rvalid !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags: got busy=%b done=%b valid=%b required 0/0/0", busy, done, rvalid);
        end
        total++;
        if (sreset !== 4'hF) begin
            bad++;
            $display("FAIL reset_solver_reset: got %b required 1111", sreset);
        end
        total++;
        if (c_re !== '0 || c_im !== '0 || rx !== '0 || ry !== '0 || rit !== '0) begin
            bad++;
            $display("FAIL reset_data: got c_re=%h c_im=%h x=%0d y=%0d it=%0d required all 0",
                     c_re, c_im, rx, ry, rit);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int nres, nd, ndone, dl, stray;
        run_sweep(FX_M2, FX_P1, FX_P05, 4, 2, 0, 0, nres, nd, ndone, dl, stray);
        total++;
        if (nres != 8 || ndone != 1) begin
            bad++;
            $display("FAIL basic_counts: got results=%0d done=%0d required 8/1", nres, ndone);
        end
        total++;
        if (disp_re[0] !== FX_M2 || disp_im[0] !== FX_P1) begin
            bad++;
            $display("FAIL basic_c00: got %h/%h required %h/%h", disp_re[0], disp_im[0], FX_M2, FX_P1);
        end
        total++;
        if (disp_re[7] !== FX_M05 || disp_im[7] !== FX_P05) begin
            bad++;
            $display("FAIL basic_c31: got %h/%h required %h/%h", disp_re[7], disp_im[7], FX_M05, FX_P05);
        end
    endtask

    task automatic test_zero_size();
        int nres, nd, ndone, dl, stray;
        run_sweep(FX_M2, FX_P1, FX_P05, 3, 0, 0, 0, nres, nd, ndone, dl, stray);
        total++;
        if (nd != 0 || stray != 0 || nres != 0) begin
            bad++;
            $display("FAIL zero_activity: got loads=%0d stray=%0d results=%0d required 0/0/0", nd, stray, nres);
        end
        total++;
        if (dl != 1 || ndone != 1) begin
            bad++;
            $display("FAIL zero_done: got latency=%0d pulses=%0d required 1/1", dl, ndone);
        end
    endtask

    task automatic test_backpressure();
        int nres, nd, ndone, dl, stray;
        run_sweep(FX_M15, FX_P1, FX_P025, 4, 4, 1, 0, nres, nd, ndone, dl, stray);
        total++;
        if (nres != 16 || nd != 16 || ndone != 1) begin
            bad++;
            $display("FAIL backpressure_counts: got results=%0d loads=%0d done=%0d required 16/16/1",
                     nres, nd, ndone);
        end
    endtask

    task automatic test_round_robin();
        int nres, nd, ndone, dl, stray;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        sim_mode = 1'b1;
        run_sweep(FX_M2, FX_P1, FX_P05, 4, 2, 0, 0, nres, nd, ndone, dl, stray);
        sim_mode = 1'b0;
        total++;
        if (nres != 8) begin
            bad++;
            $display("FAIL rr_count: got %0d required 8", nres);
        end else begin
            for (int k = 0; k < 8; k++) begin
                total++;
                if (acc_pix[k] != k) begin
                    bad++;
                    $display("FAIL rr_order index %0d: got pixel %0d required %0d", k, acc_pix[k], k);
                end
                if (k % 4 != 3) begin
                    total++;
                    if (acc_cyc[k + 1] != acc_cyc[k] + 1) begin
                        bad++;
                        $display("FAIL rr_back_to_back index %0d: got gap %0d required 1",
                                 k, acc_cyc[k + 1] - acc_cyc[k]);
                    end
                end
            end
        end
    endtask

    task automatic test_start_while_busy();
        int nres, nd, ndone, dl, stray;
        run_sweep(FX_M15, FX_P05, FX_P025, 4, 2, 0, 5, nres, nd, ndone, dl, stray);
        total++;
        if (nres != 8 || nd != 8 || ndone != 1) begin
            bad++;
            $display("FAIL restart_ignored: got results=%0d loads=%0d done=%0d required 8/8/1",
                     nres, nd, ndone);
        end
    endtask

    task automatic test_reset_mid();
        int nres, nd, ndone, dl, stray;
        @(negedge clk);
        re_s = FX_M2; im_s = FX_P1; stp = FX_P05; wd = CB'(4); ht = CB'(2);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || rvalid !== 1'b0 || done !== 1'b0 || sreset !== 4'hF) begin
            bad++;
            $display("FAIL abort_state: got busy=%b valid=%b done=%b sreset=%b required 0/0/0/1111",
                     busy, rvalid, done, sreset);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_sweep(FX_M2, FX_P1, FX_P05, 4, 2, 0, 0, nres, nd, ndone, dl, stray);
        total++;
        if (nres != 8 || nd != 8 || ndone != 1) begin
            bad++;
            $display("FAIL after_abort: got results=%0d loads=%0d done=%0d required 8/8/1",
                     nres, nd, ndone);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_size();
        test_backpressure();
        test_round_robin();
        test_start_while_busy();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mand_dispatcher.md
Name: mand_dispatcher

Overview:
- Scheduler that sweeps a rectangular pixel region of the complex plane and shares NUM_SOLVERS mandelbrot solver instances between the region's pixels.
- Generates c for each pixel in raster order, loads each free solver by holding its c and pulsing its reset, and collects finished iteration counts.
- Streams results, tagged with pixel coordinates, to the frame-buffer writer through a valid/ready port.
- Sits between the host/command logic and the solver array.

Parameters:
- NUM_SOLVERS, 4, number of attached solver instances (1..16)
- COORD_BITS, 10, width of pixel x/y counters and of region width/height

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low; clears all state while low
- start  in  1  one-cycle pulse, begins a sweep; ignored while busy
- re_start  in  27  signed 7.20 real part of pixel (0,0)
- im_start  in  27  signed 7.20 imaginary part of pixel (0,0)
- step  in  27  signed 7.20 distance between adjacent pixels
- width  in  COORD_BITS  pixels per row
- height  in  COORD_BITS  rows
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when the sweep is complete
- solver_reset  out  NUM_SOLVERS  per-solver active-high synchronous reset/load strobe
- solver_c_re  out  27*NUM_SOLVERS  per-solver c real, slot i at [27i+26:27i]
- solver_c_im  out  27*NUM_SOLVERS  per-solver c imaginary, same packing
- solver_ready  in  NUM_SOLVERS  per-solver out_ready
- solver_out  in  32*NUM_SOLVERS  per-solver iteration count (-1 = converged)
- result_valid  out  1  result word available
- result_ready  in  1  downstream accepts result
- result_x  out  COORD_BITS  pixel column of result
- result_y  out  COORD_BITS  pixel row of result
- result_iter  out  32  iteration count from solver

Behaviour:
- Reset (reset low): busy=0, done=0, result_valid=0, solver_reset=all 1s, solver_c_re/im=0, result_x/y/iter=0, all slots FREE, state IDLE.
- Top FSM: IDLE -> RUN on start. RUN -> IDLE when all pixels dispatched, all slots FREE and result_valid=0; that transition cycle asserts done=1 for exactly one cycle.
- On accepted start, latch re_start, im_start, step, width, height; x=y=0, cur_re=re_start, cur_im=im_start.
- Zero size: width=0 or height=0 -> no dispatch; done pulses the cycle after start.
- Per-slot FSM: FREE -> LOAD -> BUSY -> FREE.
- Dispatch: at most one per cycle, to the lowest-index FREE slot, while pixels remain.
  - Slot c registers take cur_re/cur_im; slot stores x,y; solver_reset[i]=1 for exactly that one LOAD cycle.
  - c registers hold stable until the slot is next loaded.
- Coordinate step: x advances by 1 and cur_re += step. At x=width-1: x=0, cur_re=re_start, y+1, cur_im -= step (imaginary decreases downward). All c arithmetic wraps mod 2^27.
- solver_ready[i] is ignored in LOAD. In BUSY, solver_ready[i]=1 marks the result complete.
- Collection: at most one per cycle, round-robin from the slot after the last collected.
  - The output register loads when result_valid=0 or (result_valid and result_ready).
  - On load, result_x/y/iter come from the slot and the slot returns FREE in the same edge.
  - A slot freed this cycle may be re-dispatched next cycle, not the same cycle.
- Handshake:
  - result_valid and the data stay stable until result_ready.
  - Back-to-back transfers give one result per cycle.
  - With result_ready=0, completed slots stall in BUSY; dispatch continues only into FREE slots.
- Results may leave out of raster order. Each pixel appears exactly once.
- Slots idle after the last dispatch keep solver_reset=0 and hold their last c.
- Reset low mid-sweep aborts immediately: no done pulse, partial results discarded.

Test Plan:
- Bench uses NUM_SOLVERS=4 real solvers; result_ready=1; start with re_start=-2.0, im_start=+1.0, step=0.5, width=4, height=2 -> 8 results, each (x,y) once. Pixel (0,0) c=(-2.0,+1.0); pixel (3,1) c=(-0.5,+0.5). Iteration counts match a golden model. done pulses once, busy falls with it.
- width=3, height=0, start -> no solver_reset pulse, no result_valid, done exactly 1 cycle after start.
- 16-pixel sweep with result_ready toggling 1-in-3 cycles -> no result lost or duplicated; result fields stable while result_valid=1 and result_ready=0.
- Behavioural solver model, all 4 solvers ready on the same cycle, result_ready=1 -> four consecutive results in round-robin order 0,1,2,3. Second simultaneous batch begins at slot 0 after slot 3.
- start pulsed again while busy -> ignored; pixel count unchanged.
- reset low for 1 cycle mid-sweep -> busy=0, result_valid=0, solver_reset all 1s. A new start then completes a full sweep correctly.
